rf_access_ctrl: RTL and testbench
=================================

# rf_access_ctrl

Command front-end for the 8x16 register file: accepts read/write commands over a valid/ready interface, buffers them in a small in-order FIFO, and drives the register file's `wren`/`rden`/`address`/`wrdata` strobes. It captures the registered read data one cycle after the read strobe and returns it on a valid/ready response channel. It sits directly upstream of the register file and guarantees `wren` and `rden` are never asserted together.

## Interface

**Parameters**
- `WIDTH`, 16, data word width; must match the register file.
- `DEPTH`, 8, number of register file entries.
- `AW`, `$clog2(DEPTH)`, address width (derived).
- `FIFO_DEPTH`, 4, command FIFO entries; power of 2, at least 2.

**Ports**
- `clk`, in, 1, clock; all logic is rising-edge.
- `rst`, in, 1, reset: asynchronous, active-low.
- `cmd_valid`, in, 1, command present.
- `cmd_ready`, out, 1, FIFO can accept a command.
- `cmd_write`, in, 1, 1 = write, 0 = read.
- `cmd_addr`, in, AW, target entry.
- `cmd_wdata`, in, WIDTH, write data; ignored for reads.
- `rsp_valid`, out, 1, read response present.
- `rsp_ready`, in, 1, consumer accepts the response.
- `rsp_data`, out, WIDTH, read data.
- `rsp_err`, out, 1, address was `>= DEPTH`; `rsp_data` = 0.
- `rf_wren`, out, 1, to register file `wren`.
- `rf_rden`, out, 1, to register file `rden`.
- `rf_address`, out, AW, to register file `address`.
- `rf_wrdata`, out, WIDTH, to register file `wrdata`.
- `rf_rddata`, in, WIDTH, from register file `rddata`.
- `busy`, out, 1, FIFO non-empty or FSM not in IDLE.

## Operation

**Commands and FIFO**
- A command is accepted on a cycle where `cmd_valid && cmd_ready`; it is pushed into the FIFO.
- `cmd_ready = rst && !fifo_full`.
- When the FIFO is full, `cmd_ready` stays 0 even if a pop happens in the same cycle (no bypass).
- The FIFO has no fall-through: a pushed entry becomes visible the next cycle.
- Commands execute strictly in order.

**FSM** (`rf_wren`, `rf_rden`, `rf_address`, `rf_wrdata` are registered)
- IDLE: if the FIFO is non-empty, pop the head and load `rf_address`/`rf_wrdata`.
  - Valid write → WR.
  - Valid read → RD.
  - Address `>= DEPTH`: a read → ERR; a write is dropped silently → IDLE.
- WR: `rf_wren` = 1 for exactly one cycle → IDLE.
- RD: `rf_rden` = 1 for exactly one cycle → CAP.
- CAP: latch `rf_rddata` into `rsp_data`, set `rsp_err` = 0 → RSP.
- ERR: set `rsp_data` = 0, `rsp_err` = 1 → RSP.
- RSP: `rsp_valid` = 1.
  - `rsp_data`/`rsp_err` are held stable until `rsp_ready`.
  - On `rsp_ready` → IDLE.

**Invariants and reset**
- `rf_wren && rf_rden` is never 1.
- Writes produce no response.
- Reset (any time, including mid-command): FSM → IDLE, FIFO emptied, and every output = 0. In-flight and queued commands are discarded.

## Timing

Cycle 0 is the accept cycle.
- Read:
  - Cycle 1: IDLE pops.
  - Cycle 2: `rf_rden` = 1.
  - Cycle 3: CAP.
  - Cycle 4: `rsp_valid` = 1.
  - Latency is 4 cycles minimum; it grows with queued commands and with `rsp_ready` backpressure.
- Write: `rf_wren` = 1 in cycle 2.
- Throughput: one write per 2 cycles; one read per 4 cycles plus the response wait.
- Read-after-write to the same address returns the new data. The write strobe precedes the read strobe by at least 2 cycles.
- While in RSP, no further commands issue; the FIFO keeps accepting until full.

## Structure

- Package `rf_pkg` holds:
  - `WIDTH`/`DEPTH`/`AW` defaults
  - the `cmd_t` struct {`write`, `addr`, `wdata`}
  - the state enum {IDLE, WR, RD, CAP, ERR, RSP}
- Sub-module `rf_cmd_fifo`: synchronous FIFO of `cmd_t` with `push`, `pop`, `full`, `empty`, and async active-low reset.
  - Pointers are one bit wider than the index, to detect full/empty.

## Test plan

- Reset, then write 0xBEEF to address 3, then read address 3 → `rf_wren` pulses in cycle 2; `rsp_valid` in cycle 4 of the read with `rsp_data` = 0xBEEF and `rsp_err` = 0.
- Back-to-back: write 5 = 0x1234, read 5, write 5 = 0x5678, read 5 → responses 0x1234 then 0x5678, in order.
- Hold `rsp_ready` = 0 and issue 5 reads → `cmd_ready` drops after 4 FIFO entries plus the 1 in flight. `rsp_data` stays stable. Releasing `rsp_ready` drains all 5 responses in order.
- With `DEPTH` = 6, read address 7 → `rsp_err` = 1, `rsp_data` = 0, and no `rf_rden` pulse. A write to address 7 → no `rf_wren` pulse.
- Assert `rst` while in RD with 3 commands queued → all outputs 0 immediately. After release: FIFO empty, `busy` = 0, `cmd_ready` = 1.
- Random traffic with an assertion check → `rf_wren && rf_rden` is never true, and each strobe lasts exactly 1 cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, command record and controller state encoding
package rf_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_DEPTH = 8;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef struct packed {
        logic                write;
        logic [RF_AW-1:0]    addr;
        logic [RF_WIDTH-1:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, WR, RD, CAP, ERR, RSP} state_t;

endpackage

// File: rtl/rf_cmd_fifo.sv
// rf_cmd_fifo: in-order command queue, no fall-through, extra pointer bit tells full from empty
module rf_cmd_fifo
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    cmd_t        r_mem [FIFO_DEPTH];
    logic        w_push;
    logic        w_pop;

    assign o_empty = r_wr_ptr == r_rd_ptr;
    assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[PW-1:0]];

    // advance pointers on accepted push/pop; reset empties the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // storage needs no reset, the pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: queued read/write front-end driving the register file strobes
module rf_access_ctrl
    import rf_pkg::*;
#(
    parameter int WIDTH      = RF_WIDTH,
    parameter int DEPTH      = RF_DEPTH,
    parameter int AW         = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             rf_wren,
    output logic             rf_rden,
    output logic [AW-1:0]    rf_address,
    output logic [WIDTH-1:0] rf_wrdata,
    input  logic [WIDTH-1:0] rf_rddata,
    output logic             busy
);

    state_t           r_state;
    logic             r_wren;
    logic             r_rden;
    logic [AW-1:0]    r_address;
    logic [WIDTH-1:0] r_wrdata;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;
    cmd_t             w_push_cmd;
    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_addr_ok;

    assign w_push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready  = rst && !w_full;
    assign w_pop      = (r_state == IDLE) && !w_empty;
    assign w_addr_ok  = {1'b0, w_head.addr} < (AW+1)'(DEPTH);
    assign busy       = !w_empty || (r_state != IDLE);
    assign rf_wren    = r_wren;
    assign rf_rden    = r_rden;
    assign rf_address = r_address;
    assign rf_wrdata  = r_wrdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;

    rf_cmd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (cmd_valid && cmd_ready),
        .i_data (w_push_cmd),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    // one command at a time: pop, strobe for a single cycle, then return read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wren      <= 1'b0;
            r_rden      <= 1'b0;
            r_address   <= '0;
            r_wrdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (!w_empty) begin
                    r_address <= w_head.addr;
                    r_wrdata  <= w_head.wdata;
                    if (!w_addr_ok) begin
                        r_state <= w_head.write ? IDLE : ERR;
                    end else if (w_head.write) begin
                        r_wren  <= 1'b1;
                        r_state <= WR;
                    end else begin
                        r_rden  <= 1'b1;
                        r_state <= RD;
                    end
                end
                WR: begin
                    r_wren  <= 1'b0;
                    r_state <= IDLE;
                end
                RD: begin
                    r_rden  <= 1'b0;
                    r_state <= CAP;
                end
                CAP: begin
                    r_rsp_data  <= rf_rddata;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RSP;
                end
                ERR: begin
                    r_rsp_data  <= '0;
                    r_rsp_err   <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RSP;
                end
                RSP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: directed checks of the register file front-end plus a random in-order run
module tb_rf_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        cmd_valid0 = 1'b0;
    logic        cmd_valid1 = 1'b0;
    logic        cmd_write = 1'b0;
    logic [2:0]  cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b0;

    logic        cmd_ready0, rsp_valid0, rsp_err0, rf_wren, rf_rden, busy0;
    logic [15:0] rsp_data0, rf_wrdata, rf_rddata;
    logic [2:0]  rf_address;
    logic        cmd_ready1, rsp_valid1, rsp_err1, rf_wren1, rf_rden1, busy1;
    logic [15:0] rsp_data1, rf_wrdata1;
    logic [15:0] rf_rddata1;
    logic [2:0]  rf_address1;
    logic        s_ready, s_valid, s_err;
    logic [15:0] s_data;

    int n_chk = 0;
    int n_err = 0;
    int rden1_cnt = 0;
    int wren1_cnt = 0;
    logic p_wren = 1'b0;
    logic p_rden = 1'b0;
    logic [15:0] rf_mem [8];

    always #5 clk = ~clk;

    assign rf_rddata1 = 16'hA5A5;
    assign s_ready = sel ? cmd_ready1 : cmd_ready0;
    assign s_valid = sel ? rsp_valid1 : rsp_valid0;
    assign s_err   = sel ? rsp_err1 : rsp_err0;
    assign s_data  = sel ? rsp_data1 : rsp_data0;

    rf_access_ctrl u0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0), .rsp_err(rsp_err0),
        .rf_wren(rf_wren), .rf_rden(rf_rden), .rf_address(rf_address),
        .rf_wrdata(rf_wrdata), .rf_rddata(rf_rddata), .busy(busy0)
    );

    rf_access_ctrl #(.DEPTH(6)) u1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
        .rf_wren(rf_wren1), .rf_rden(rf_rden1), .rf_address(rf_address1),
        .rf_wrdata(rf_wrdata1), .rf_rddata(rf_rddata1), .busy(busy1)
    );

    // register file: synchronous write, registered read
    always @(posedge clk) begin
        if (rf_wren) rf_mem[rf_address] <= rf_wrdata;
        if (rf_rden) rf_rddata <= rf_mem[rf_address];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // strobe exclusivity and single-cycle width, plus strobe counts on the short instance
    always @(negedge clk) begin
        if (rst) begin
            check("excl", rf_wren && rf_rden, 0);
            check("wren_1cyc", p_wren && rf_wren, 0);
            check("rden_1cyc", p_rden && rf_rden, 0);
        end
        p_wren = rf_wren;
        p_rden = rf_rden;
        if (rf_rden1) rden1_cnt++;
        if (rf_wren1) wren1_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic w, input logic [2:0] a, input logic [15:0] d);
        int n = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!s_ready && n < 100) begin
            tick(1);
            n++;
        end
        check("send_rdy", s_ready, 1);
        cmd_valid0 = !sel;
        cmd_valid1 = sel;
        tick(1);
        cmd_valid0 = 1'b0;
        cmd_valid1 = 1'b0;
    endtask

    task automatic collect(input logic [15:0] d, input logic e);
        int n = 0;
        while (!s_valid && n < 100) begin
            tick(1);
            n++;
        end
        check("rsp_valid", s_valid, 1);
        check("rsp_data", s_data, d);
        check("rsp_err", s_err, e);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 200) begin
            tick(1);
            n++;
        end
        check("idle", busy0 || busy1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        logic [15:0] sh [8];
        logic        cw [48];
        logic [2:0]  ca [48];
        logic [15:0] cd [48];
        logic [15:0] exp_q [$];

        // reset state
        tick(3);
        check("rst_cmd_ready", cmd_ready0, 0);
        check("rst_busy", busy0, 0);
        check("rst_rsp_valid", rsp_valid0, 0);
        check("rst_wren", rf_wren, 0);
        rst = 1'b1;
        tick(1);
        check("post_rst_ready", cmd_ready0, 1);
        check("post_rst_busy", busy0, 0);

        // write then read with cycle-exact strobes
        send(1, 3, 16'hBEEF);
        check("wr_c1_wren", rf_wren, 0);
        tick(1);
        check("wr_c2_wren", rf_wren, 1);
        check("wr_c2_addr", rf_address, 3);
        check("wr_c2_data", rf_wrdata, 16'hBEEF);
        tick(1);
        check("wr_c3_wren", rf_wren, 0);
        send(0, 3, 16'h0);
        check("rd_c1_rden", rf_rden, 0);
        tick(1);
        check("rd_c2_rden", rf_rden, 1);
        check("rd_c2_addr", rf_address, 3);
        tick(1);
        check("rd_c3_rden", rf_rden, 0);
        check("rd_c3_valid", rsp_valid0, 0);
        tick(1);
        check("rd_c4_valid", rsp_valid0, 1);
        collect(16'hBEEF, 0);

        // back-to-back read-after-write ordering
        send(1, 5, 16'h1234);
        send(0, 5, 16'h0);
        send(1, 5, 16'h5678);
        send(0, 5, 16'h0);
        collect(16'h1234, 0);
        collect(16'h5678, 0);
        wait_idle();

        // backpressure: 4 queued plus 1 in flight fills the front-end
        for (int i = 0; i < 5; i++) send(1, 3'(i), 16'h1000 + 16'(i));
        wait_idle();
        for (int i = 0; i < 5; i++) send(0, 3'(i), 16'h0);
        check("bp_ready", cmd_ready0, 0);
        check("bp_busy", busy0, 1);
        tick(3);
        check("bp_valid", rsp_valid0, 1);
        check("bp_hold1", rsp_data0, 16'h1000);
        tick(3);
        check("bp_hold2", rsp_data0, 16'h1000);
        check("bp_ready2", cmd_ready0, 0);
        for (int i = 0; i < 5; i++) collect(16'h1000 + 16'(i), 0);
        wait_idle();

        // out-of-range address on a 6-entry instance
        sel = 1'b1;
        c0 = rden1_cnt;
        send(0, 7, 16'h0);
        collect(16'h0, 1);
        check("err_no_rden", rden1_cnt - c0, 0);
        c1 = wren1_cnt;
        send(1, 7, 16'hFFFF);
        tick(5);
        check("err_no_wren", wren1_cnt - c1, 0);
        check("err_wr_busy", busy1, 0);
        check("err_wr_no_rsp", rsp_valid1, 0);
        c0 = rden1_cnt;
        send(0, 2, 16'h0);
        collect(16'hA5A5, 0);
        check("ok_rden", rden1_cnt - c0, 1);
        sel = 1'b0;
        wait_idle();

        // reset while in RD with 3 commands queued
        for (int i = 1; i < 6; i++) send(0, 3'(i == 5 ? 1 : i), 16'h0);
        c0 = 0;
        while (!rsp_valid0 && c0 < 50) begin
            tick(1);
            c0++;
        end
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        tick(1);
        check("pre_rst_rden", rf_rden, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_rden", rf_rden, 0);
        check("mid_rst_wren", rf_wren, 0);
        check("mid_rst_addr", rf_address, 0);
        check("mid_rst_wrdata", rf_wrdata, 0);
        check("mid_rst_valid", rsp_valid0, 0);
        check("mid_rst_data", rsp_data0, 0);
        check("mid_rst_err", rsp_err0, 0);
        check("mid_rst_ready", cmd_ready0, 0);
        check("mid_rst_busy", busy0, 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("rel_busy", busy0, 0);
        check("rel_ready", cmd_ready0, 1);
        tick(8);
        check("rel_no_rsp", rsp_valid0, 0);
        check("rel_busy2", busy0, 0);

        // random in-order traffic against a shadow of the register file
        for (int i = 0; i < 48; i++) begin
            cw[i] = i < 8 ? 1'b1 : 1'($urandom_range(0, 1));
            ca[i] = i < 8 ? 3'(i) : 3'($urandom_range(0, 7));
            cd[i] = i < 8 ? 16'h1111 * 16'(i) : 16'($urandom);
            if (cw[i]) sh[ca[i]] = cd[i];
            else exp_q.push_back(sh[ca[i]]);
        end
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    send(cw[i], ca[i], cd[i]);
                    if ($urandom_range(0, 3) == 0) tick(1);
                end
            end
            begin
                int got = 0;
                int t = 0;
                while (got < exp_q.size() && t < 5000) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    if (rsp_valid0 && rsp_ready) begin
                        check("rnd_data", rsp_data0, exp_q[got]);
                        check("rnd_err", rsp_err0, 0);
                        got++;
                    end
                    tick(1);
                    t++;
                end
                rsp_ready = 1'b0;
                check("rnd_count", got, exp_q.size());
            end
        join
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
